// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the core's instruction-fetch and data ports.
// One request at a time is accepted from IDLE. Its address, store data,
// funct3 and read/write flags are snapshotted. After LATENCY wait cycles the
// word array is accessed, and the owning port gets a one-cycle ready pulse
// with the result.
//
// Parameters
//   ADDR_W   log2 of array depth in 32-bit words (word index = addr[ADDR_W+1:2])
//   LATENCY  wait cycles between acceptance and access, 1..15
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   flush_i        cancels an in-flight instruction fetch (BUSY) or masks
//                  its ready pulse (RESP); no effect on data transactions
//   validInsReq_i  instruction fetch request (level)
//   PC_i           fetch byte address, bits [1:0] ignored
//   Mread_i        data load request (level)
//   Mwrite_i       data store request (level); with Mread_i it is a store
//   Addr_i         data byte address
//   WriteD_i       right-aligned store data
//   funct3_i       RV32I load/store size and sign
//   Instr_o        fetched word, held until the next fetch response
//   ReadD_o        aligned/extended load result, held until the next
//                  data response that updates it
//   IMemReady_o    one-cycle fetch response pulse
//   DMemReady_o    one-cycle data response pulse
//
// Build option
//   MEMRESP_ROUND_ROBIN_EN  when defined, simultaneous fetch/data requests
//                           alternate, starting with data; otherwise data
//                           always wins the tie.
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        validInsReq_i,
    input  logic [31:0] PC_i,
    input  logic        Mread_i,
    input  logic        Mwrite_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WriteD_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] Instr_o,
    output logic [31:0] ReadD_o,
    output logic        IMemReady_o,
    output logic        DMemReady_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;

    // tag_i = 1: transaction belongs to the fetch port, 0: data port
    logic              tag_i;
    logic [ADDR_W-1:0] snap_idx;
    logic [1:0]        snap_lane;
    logic [31:0]       snap_wdata;
    logic [2:0]        snap_f3;
    logic              snap_rd;
    logic              snap_wr;

    logic              data_req;
    logic              tie_to_fetch;
    logic              fetch_wins;
    logic              accept;
    logic              do_access;
    logic [ADDR_W-1:0] req_idx;
    logic [1:0]        req_lane;

    logic [31:0]       mem [0:(2**ADDR_W)-1];
    logic [31:0]       rd_word;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    // Address bits above the array and the fetch byte offset are don't-care.
    logic              addr_hi_unused;
    assign addr_hi_unused = ^{PC_i[31:ADDR_W+2], PC_i[1:0], Addr_i[31:ADDR_W+2]};

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign data_req   = Mread_i | Mwrite_i;
    assign fetch_wins = validInsReq_i & (~data_req | tie_to_fetch);
    assign req_idx    = fetch_wins ? PC_i[ADDR_W+1:2] : Addr_i[ADDR_W+1:2];
    assign req_lane   = fetch_wins ? 2'b00 : Addr_i[1:0];

`ifdef MEMRESP_ROUND_ROBIN_EN
    // Last-served port; starts as fetch so that data takes the first tie.
    logic last_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_i <= 1'b1;
        end else if (accept) begin
            last_i <= fetch_wins;
        end
    end

    assign tie_to_fetch = ~last_i;
`else
    assign tie_to_fetch = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state)
            S_IDLE: begin
                if (data_req || validInsReq_i) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (tag_i && flush_i) begin
                    // Aborted fetch: no access, no pulse.
                    cnt_nxt   = 4'd0;
                    state_nxt = S_IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request snapshot and registered result outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_i      <= 1'b0;
            snap_idx   <= '0;
            snap_lane  <= 2'b00;
            snap_wdata <= 32'd0;
            snap_f3    <= 3'd0;
            snap_rd    <= 1'b0;
            snap_wr    <= 1'b0;
            Instr_o    <= 32'd0;
            ReadD_o    <= 32'd0;
        end else begin
            if (accept) begin
                tag_i      <= fetch_wins;
                snap_idx   <= req_idx;
                snap_lane  <= req_lane;
                snap_wdata <= WriteD_i;
                snap_f3    <= funct3_i;
                snap_rd    <= ~fetch_wins & Mread_i;
                snap_wr    <= ~fetch_wins & Mwrite_i;
            end
            if (do_access) begin
                if (tag_i) begin
                    Instr_o <= rd_word;
                end else if (snap_wr) begin
                    // Combined read+write is a store that returns zero;
                    // a plain store leaves the previous load result alone.
                    if (snap_rd) begin
                        ReadD_o <= 32'd0;
                    end
                end else begin
                    ReadD_o <= load_align(rd_word, snap_lane, snap_f3);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load alignment / extension
    // ------------------------------------------------------------------
    function automatic logic [31:0] load_align(input logic [31:0] w,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_align = {{24{b[7]}}, b};
            3'b100:  load_align = {24'd0, b};
            3'b001:  load_align = {{16{h[15]}}, h};
            3'b101:  load_align = {16'd0, h};
            default: load_align = w;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Store byte enables and lane-replicated data
    // ------------------------------------------------------------------
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = snap_wdata;
        case (snap_f3)
            3'b000: begin
                wr_be   = 4'b0001 << snap_lane;
                wr_data = {4{snap_wdata[7:0]}};
            end
            3'b001: begin
                wr_be   = snap_lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{snap_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = snap_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word array (not reset). Writes are gated by rst_i so a reset that
    // coincides with the access edge still suppresses the store.
    // ------------------------------------------------------------------
    assign rd_word = mem[snap_idx];

    always_ff @(posedge clk_i) begin
        if (do_access && !tag_i && snap_wr && !rst_i) begin
            if (wr_be[0]) mem[snap_idx][7:0]   <= wr_data[7:0];
            if (wr_be[1]) mem[snap_idx][15:8]  <= wr_data[15:8];
            if (wr_be[2]) mem[snap_idx][23:16] <= wr_data[23:16];
            if (wr_be[3]) mem[snap_idx][31:24] <= wr_data[31:24];
        end
    end

    // ------------------------------------------------------------------
    // Ready pulses
    // ------------------------------------------------------------------
    assign IMemReady_o = (state == S_RESP) & tag_i & ~flush_i;
    assign DMemReady_o = (state == S_RESP) & ~tag_i;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int ADDR_W = 12;
    localparam int LAT    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        vins;
    logic [31:0] pc;
    logic        mread;
    logic        mwrite;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] instr;
    logic [31:0] readd;
    logic        irdy;
    logic        drdy;

    int vectors = 0;
    int errs    = 0;

    // Reference model state
    logic [31:0] mem_m [0:(1<<ADDR_W)-1];
    logic [31:0] exp_instr;
    logic [31:0] exp_readd;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .validInsReq_i(vins),
        .PC_i         (pc),
        .Mread_i      (mread),
        .Mwrite_i     (mwrite),
        .Addr_i       (addr),
        .WriteD_i     (wd),
        .funct3_i     (f3),
        .Instr_o      (instr),
        .ReadD_o      (readd),
        .IMemReady_o  (irdy),
        .DMemReady_o  (drdy)
    );

    // Reference: load extraction by shifting and arithmetic extension
    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [2:0] fn);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lane)) & 32'hFF;
        h = (w >> (16 * lane[1])) & 32'hFFFF;
        case (fn)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // Reference: read-modify-write merge with a byte mask
    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] d,
                                            input logic [1:0] lane, input logic [2:0] fn);
        logic [31:0] mask;
        logic [31:0] val;
        case (fn)
            3'd0: begin
                mask = 32'hFF << (8 * lane);
                val  = (d & 32'hFF) << (8 * lane);
            end
            3'd1: begin
                mask = 32'hFFFF << (16 * lane[1]);
                val  = (d & 32'hFFFF) << (16 * lane[1]);
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                val  = d;
            end
        endcase
        return (w & ~mask) | (val & mask);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction started in the current cycle (cycle 0).
    task automatic txn(input string tag, input bit f, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] fn);
        int               lat;
        bit               got;
        logic [ADDR_W-1:0] idx;
        idx = a[ADDR_W+1:2];
        if (f) begin
            exp_instr = mem_m[idx];
        end else if (wr) begin
            mem_m[idx] = m_store(mem_m[idx], d, a[1:0], fn);
            if (rd) exp_readd = 32'd0;
        end else begin
            exp_readd = m_load(mem_m[idx], a[1:0], fn);
        end
        if (f) begin
            vins = 1'b1;
            pc   = a;
        end else begin
            mread  = rd;
            mwrite = wr;
            addr   = a;
            wd     = d;
            f3     = fn;
        end
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            step();
            if (k == 1) begin
                vins   = 1'b0;
                mread  = 1'b0;
                mwrite = 1'b0;
            end
            chk({tag, " other_rdy"}, {31'd0, (f ? drdy : irdy)}, 32'd0);
            if (f ? irdy : drdy) begin
                got = 1'b1;
                lat = k;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(LAT + 1));
        chk({tag, " instr"}, instr, exp_instr);
        chk({tag, " readd"}, readd, exp_readd);
        step();
        chk({tag, " pulse_width"}, {30'd0, irdy, drdy}, 32'd0);
    endtask

    initial begin
        int dlat;
        int ilat;
        logic [31:0] a;
        logic [31:0] hi;
        int kind;

        rst    = 1'b1;
        flush  = 1'b0;
        vins   = 1'b0;
        pc     = 32'd0;
        mread  = 1'b0;
        mwrite = 1'b0;
        addr   = 32'd0;
        wd     = 32'd0;
        f3     = 3'd0;
        exp_instr = 32'd0;
        exp_readd = 32'd0;

        // Reset state
        step();
        step();
        chk("rst instr", instr, 32'd0);
        chk("rst readd", readd, 32'd0);
        chk("rst rdy",   {30'd0, irdy, drdy}, 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst rdy", {30'd0, irdy, drdy}, 32'd0);

        // Word store/load and extensions
        txn("sw40",  0, 0, 1, 32'h40, 32'hDEADBEEF, 3'b010);
        txn("lw40",  0, 1, 0, 32'h40, 32'h0, 3'b010);
        chk("lw40 const", readd, 32'hDEADBEEF);
        txn("lb43",  0, 1, 0, 32'h43, 32'h0, 3'b000);
        chk("lb43 const", readd, 32'hFFFFFFDE);
        txn("lbu43", 0, 1, 0, 32'h43, 32'h0, 3'b100);
        chk("lbu43 const", readd, 32'h000000DE);
        txn("lh42",  0, 1, 0, 32'h42, 32'h0, 3'b001);
        chk("lh42 const", readd, 32'hFFFFDEAD);

        // Simultaneous fetch and load: data first
        vins  = 1'b1;
        pc    = 32'h40;
        mread = 1'b1;
        addr  = 32'h40;
        f3    = 3'b010;
        exp_readd = mem_m[32'h10];
        exp_instr = mem_m[32'h10];
        dlat = 0;
        ilat = 0;
        for (int k = 1; k <= 20 && ilat == 0; k++) begin
            step();
            if (k == 1) mread = 1'b0;
            chk("tie both_rdy", {31'd0, irdy & drdy}, 32'd0);
            if (drdy && dlat == 0) begin
                dlat = k;
                chk("tie readd", readd, exp_readd);
            end
            if (irdy) begin
                ilat = k;
                vins = 1'b0;
                chk("tie instr", instr, 32'hDEADBEEF);
            end
        end
        chk("tie dlat", 32'(dlat), 32'(LAT + 1));
        chk("tie ilat", 32'(ilat), 32'(2 * LAT + 3));
        vins = 1'b0;
        step();

        txn("sb41", 0, 0, 1, 32'h41, 32'h11, 3'b000);
        txn("lw40b", 0, 1, 0, 32'h40, 32'h0, 3'b010);
        chk("sb lw const", readd, 32'hDEAD11EF);

        // Flush during BUSY aborts the fetch
        vins = 1'b1;
        pc   = 32'h40;
        step();
        vins = 1'b0;
        chk("flush c1 irdy", {31'd0, irdy}, 32'd0);
        step();
        flush = 1'b1;
        chk("flush c2 irdy", {31'd0, irdy}, 32'd0);
        step();
        flush = 1'b0;
        chk("flush c3 irdy", {31'd0, irdy}, 32'd0);
        txn("fetch_after_flush", 1, 0, 0, 32'h40, 32'h0, 3'b010);

        // Flush during RESP masks the pulse but the word is still captured
        exp_instr = mem_m[32'h11];
        vins = 1'b1;
        pc   = 32'h44;
        for (int k = 1; k <= LAT + 1; k++) begin
            step();
            if (k == 1) vins = 1'b0;
            if (k == LAT + 1) begin
                flush = 1'b1;
                #1;
            end
            chk("flush_resp irdy", {31'd0, irdy}, 32'd0);
        end
        flush = 1'b0;
        step();
        chk("flush_resp instr", instr, exp_instr);

        // Randomized traffic over a 16-word window, upper bits random (wrap)
        for (int i = 0; i < 16; i++)
            txn("init", 0, 0, 1, 32'h100 + 32'(4 * i), $urandom, 3'b010);
        for (int i = 0; i < 60; i++) begin
            hi   = $urandom;
            a    = (hi & 32'hFFFF_C000) | 32'h100 | (32'($urandom_range(0, 15)) << 2)
                   | 32'($urandom_range(0, 3));
            kind = $urandom_range(0, 3);
            if (kind != 0) flush = 1'($urandom_range(0, 1));
            case (kind)
                0:       txn("rnd_fetch", 1, 0, 0, a, 32'h0, 3'b010);
                1:       txn("rnd_load",  0, 1, 0, a, 32'h0, 3'($urandom_range(0, 7)));
                2:       txn("rnd_store", 0, 0, 1, a, $urandom, 3'($urandom_range(0, 7)));
                default: txn("rnd_rdwr",  0, 1, 1, a, $urandom, 3'($urandom_range(0, 7)));
            endcase
            flush = 1'b0;
        end

        // Reset in the middle of a store
        txn("sw80_zero", 0, 0, 1, 32'h80, 32'h0, 3'b010);
        mwrite = 1'b1;
        addr   = 32'h80;
        wd     = 32'h12345678;
        f3     = 3'b010;
        step();
        mwrite = 1'b0;
        chk("rst_mid c1 drdy", {31'd0, drdy}, 32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid instr", instr, 32'd0);
        chk("rst_mid readd", readd, 32'd0);
        chk("rst_mid rdy", {30'd0, irdy, drdy}, 32'd0);
        step();
        rst = 1'b0;
        exp_instr = 32'd0;
        exp_readd = 32'd0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rst_mid no_pulse", {30'd0, irdy, drdy}, 32'd0);
        end
        txn("lw80_after_rst", 0, 1, 0, 32'h80, 32'h0, 3'b010);
        chk("lw80 const", readd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
